// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multi-cycle control path and immediate generator
package rv_ctrl_pkg;

    // Immediate generator Type select, shared with the immediate generator
    localparam logic [2:0] RTYPE  = 3'b000;
    localparam logic [2:0] ITYPE  = 3'b001;
    localparam logic [2:0] STYPE  = 3'b010;
    localparam logic [2:0] BTYPE  = 3'b011;
    localparam logic [2:0] UTYPE  = 3'b100;
    localparam logic [2:0] JTYPE  = 3'b101;
    localparam logic [2:0] LITYPE = 3'b110;
    localparam logic [2:0] LJTYPE = 3'b111;

    // RV32I major opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DMEM = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode classifier and immediate Type select
module opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_type_o,
    output logic       legal_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jal_o,
    output logic       is_jalr_o
);

    // Map each major opcode to its immediate format and instruction class
    always_comb begin
        imm_type_o  = RTYPE;
        legal_o     = 1'b1;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_branch_o = 1'b0;
        is_jal_o    = 1'b0;
        is_jalr_o   = 1'b0;
        case (opcode_i)
            OP_REG:           imm_type_o = RTYPE;
            OP_IMM:           imm_type_o = ITYPE;
            OP_STORE:  begin  imm_type_o = STYPE;  is_store_o  = 1'b1; end
            OP_BRANCH: begin  imm_type_o = BTYPE;  is_branch_o = 1'b1; end
            OP_LUI, OP_AUIPC: imm_type_o = UTYPE;
            OP_JAL:    begin  imm_type_o = JTYPE;  is_jal_o    = 1'b1; end
            OP_LOAD:   begin  imm_type_o = LITYPE; is_load_o   = 1'b1; end
            OP_JALR:   begin  imm_type_o = LJTYPE; is_jalr_o   = 1'b1; end
            default:          legal_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with memory time-out
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic [2:0]  imm_type,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [6:0]    opc_q, opc_d;
    logic [2:0]    imm_q, imm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;

    logic [2:0] dec_imm;
    logic       dec_legal, is_load, is_store, is_branch, is_jal, is_jalr;

    // Classification always follows the latched opcode, never the live bus
    opcode_decode u_dec (
        .opcode_i    (opc_q),
        .imm_type_o  (dec_imm),
        .legal_o     (dec_legal),
        .is_load_o   (is_load),
        .is_store_o  (is_store),
        .is_branch_o (is_branch),
        .is_jal_o    (is_jal),
        .is_jalr_o   (is_jalr)
    );

    // State register plus opcode, immediate type, wait counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opc_q     <= '0;
            imm_q     <= RTYPE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic; a ready arriving on the last wait cycle beats the time-out
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    opc_d   = imem_rdata[6:0];
                    state_d = ST_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                imm_d = dec_imm;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) state_d = ST_MEM;
                else if (is_branch)      state_d = ST_FETCH;
                else                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = is_load ? ST_WB : ST_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        // Every state change restarts the wait count, so FETCH and MEM start at zero
        if (state_d != state_q) cnt_d = '0;
    end

    // Output decode; strobes are forced low while reset is held
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        wb_sel   = WB_ALU;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                    end else if (is_jal) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_IMM;
                    end else if (is_jalr) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_ALU;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = is_store && dmem_ready;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    if (is_load)               wb_sel = WB_DMEM;
                    else if (is_jal || is_jalr) wb_sel = WB_PC4;
                    pc_we = !(is_jal || is_jalr);
                end
                default: ;
            endcase
        end
    end

    assign imm_type = imm_q;
    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, illegal, bus_err;
    logic [2:0]  imm_type, state;
    logic [1:0]  pc_sel, wb_sel;

    int total = 0;
    int bad = 0;
    int n_imem = 0;
    int n_dmem = 0;
    int n_reg = 0;
    int n_pc = 0;

    multicycle_ctrl #(.TIMEOUT(4), .CW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .imm_type     (imm_type),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Per-cycle strobe tallies, sampled mid-cycle
    always @(negedge clk) begin
        n_imem <= n_imem + int'(imem_req);
        n_dmem <= n_dmem + int'(dmem_req);
        n_reg  <= n_reg + int'(reg_we);
        n_pc   <= n_pc + int'(pc_we);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        branch_taken = 1'b0;
        settle;
        check({tag, "_rst_state"}, 32'(state), 32'd0);
        check({tag, "_rst_imemreq"}, 32'(imem_req), 32'd0);
        check({tag, "_rst_imm"}, 32'(imm_type), 32'd0);
        check({tag, "_rst_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_rst_buserr"}, 32'(bus_err), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Holds FETCH for 'waits' cycles, then delivers instr; returns in DECODE
    task automatic fetch(input logic [31:0] instr, input int waits, input string tag);
        for (int i = 0; i < waits; i++) begin
            settle;
            check({tag, "_fetch_req"}, 32'(imem_req), 32'd1);
            tick;
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        settle;
        check({tag, "_ir_we"}, 32'(ir_we), 32'd1);
        tick;
        imem_ready = 1'b0;
        check({tag, "_decode"}, 32'(state), 32'd1);
    endtask

    int b_reg, b_pc, b_dmem, b_imem;

    initial begin
        do_reset("init");

        // ADD: ready on 2nd FETCH cycle, back in FETCH 4 edges after ready cycle
        b_reg = n_reg; b_pc = n_pc;
        fetch(32'h0020_8033, 1, "add");
        tick;
        check("add_exec", 32'(state), 32'd2);
        check("add_imm", 32'(imm_type), 32'd0);
        tick;
        settle;
        check("add_wb_state", 32'(state), 32'd4);
        check("add_reg_we", 32'(reg_we), 32'd1);
        check("add_pc_we", 32'(pc_we), 32'd1);
        check("add_pc_sel", 32'(pc_sel), 32'd0);
        check("add_wb_sel", 32'(wb_sel), 32'd0);
        tick;
        check("add_back_fetch", 32'(state), 32'd0);
        check("add_n_reg", 32'(n_reg - b_reg), 32'd1);
        check("add_n_pc", 32'(n_pc - b_pc), 32'd1);

        // LW: dmem_ready on 3rd MEM cycle
        b_reg = n_reg; b_pc = n_pc;
        fetch(32'h0000_A103, 0, "lw");
        tick;
        check("lw_imm", 32'(imm_type), 32'd6);
        tick;
        b_dmem = n_dmem;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2);
            settle;
            check("lw_mem_state", 32'(state), 32'd3);
            check("lw_dmem_req", 32'(dmem_req), 32'd1);
            check("lw_dmem_we", 32'(dmem_we), 32'd0);
            check("lw_mem_pc_we", 32'(pc_we), 32'd0);
            tick;
        end
        dmem_ready = 1'b0;
        settle;
        check("lw_wb_state", 32'(state), 32'd4);
        check("lw_reg_we", 32'(reg_we), 32'd1);
        check("lw_wb_sel", 32'(wb_sel), 32'd1);
        tick;
        check("lw_back_fetch", 32'(state), 32'd0);
        check("lw_n_dmem", 32'(n_dmem - b_dmem), 32'd3);
        check("lw_n_pc", 32'(n_pc - b_pc), 32'd1);
        check("lw_n_reg", 32'(n_reg - b_reg), 32'd1);

        // BEQ taken then not taken
        b_reg = n_reg;
        for (int t = 0; t < 2; t++) begin
            fetch(32'h0000_0463, 0, "beq");
            tick;
            branch_taken = (t == 0);
            settle;
            check("beq_imm", 32'(imm_type), 32'd3);
            check("beq_pc_we", 32'(pc_we), 32'd1);
            check("beq_pc_sel", 32'(pc_sel), (t == 0) ? 32'd1 : 32'd0);
            tick;
            branch_taken = 1'b0;
            check("beq_back_fetch", 32'(state), 32'd0);
        end
        check("beq_no_reg_we", 32'(n_reg - b_reg), 32'd0);

        // JAL: PC updated in EXEC, link written in WB without a second pc_we
        fetch(32'h0000_006F, 0, "jal");
        tick;
        settle;
        check("jal_imm", 32'(imm_type), 32'd5);
        check("jal_pc_we", 32'(pc_we), 32'd1);
        check("jal_pc_sel", 32'(pc_sel), 32'd1);
        tick;
        settle;
        check("jal_reg_we", 32'(reg_we), 32'd1);
        check("jal_wb_sel", 32'(wb_sel), 32'd2);
        check("jal_wb_pc_we", 32'(pc_we), 32'd0);
        tick;
        check("jal_back_fetch", 32'(state), 32'd0);

        // SW completing on the first MEM cycle
        fetch(32'h0020_A023, 0, "sw");
        tick;
        check("sw_imm", 32'(imm_type), 32'd2);
        tick;
        dmem_ready = 1'b1;
        settle;
        check("sw_dmem_we", 32'(dmem_we), 32'd1);
        check("sw_pc_we", 32'(pc_we), 32'd1);
        check("sw_pc_sel", 32'(pc_sel), 32'd0);
        check("sw_reg_we", 32'(reg_we), 32'd0);
        tick;
        dmem_ready = 1'b0;
        check("sw_back_fetch", 32'(state), 32'd0);

        // SW with reset dropped mid-MEM
        fetch(32'h0020_A023, 0, "swr");
        tick;
        tick;
        settle;
        check("swr_dmem_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("swr_req_drop", 32'(dmem_req), 32'd0);
        check("swr_state", 32'(state), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        settle;
        check("swr_first_imem_req", 32'(imem_req), 32'd1);
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0;
        check("stray_dmem_ready", 32'(state), 32'd0);

        // Illegal opcode 0x7F
        fetch(32'h0000_007F, 0, "ill");
        tick;
        check("ill_halt", 32'(state), 32'd7);
        check("ill_flag", 32'(illegal), 32'd1);
        b_imem = n_imem;
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        tick;
        check("ill_held", 32'(state), 32'd7);
        check("ill_no_imem_req", 32'(n_imem - b_imem), 32'd0);
        do_reset("ill");

        // Time-out with no imem_ready
        b_imem = n_imem;
        for (int i = 0; i < 4; i++) tick;
        check("to_state", 32'(state), 32'd7);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_req_drop", 32'(imem_req), 32'd0);
        tick;
        check("to_n_imem", 32'(n_imem - b_imem), 32'd4);
        do_reset("to");

        // Ready on the last permitted cycle wins
        fetch(32'h0020_8033, 3, "to_ok");
        check("to_ok_bus_err", 32'(bus_err), 32'd0);
        tick;
        check("to_ok_exec", 32'(state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
